// File: rtl/icache_fill_if.sv
// Fill-engine bus bundle: controller request, memory request/response,
// data-array and tag-array write ports, plus the error pulse.
interface icache_fill_if #(
    parameter int ADDR_W = 56
);
    logic              ctrl2fill_valid;
    logic [5:0]        ctrl2fill_index;
    logic [2:0]        ctrl2fill_way;
    logic [ADDR_W-13:0] ctrl2fill_tag;
    logic              fill2ctrl_ready;

    logic              mem_req_valid;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_req_ready;

    logic              mem_resp_valid;
    logic [63:0]       mem_resp_data;
    logic              mem_resp_last;
    logic              mem_resp_ready;

    logic              fill2data_wen;
    logic [5:0]        fill2data_index;
    logic [2:0]        fill2data_way;
    logic [2:0]        fill2data_offset;
    logic [63:0]       fill2data_wdata;

    logic              fill2tag_wen;
    logic [5:0]        fill2tag_index;
    logic [2:0]        fill2tag_way;
    logic [ADDR_W-13:0] fill2tag_tag;
    logic              fill2tag_valid;

    logic              fill_err;

    modport slave (
        input  ctrl2fill_valid, ctrl2fill_index, ctrl2fill_way, ctrl2fill_tag,
        output fill2ctrl_ready,
        output mem_req_valid, mem_req_addr,
        input  mem_req_ready,
        input  mem_resp_valid, mem_resp_data, mem_resp_last,
        output mem_resp_ready,
        output fill2data_wen, fill2data_index, fill2data_way,
        output fill2data_offset, fill2data_wdata,
        output fill2tag_wen, fill2tag_index, fill2tag_way,
        output fill2tag_tag, fill2tag_valid,
        output fill_err
    );

    modport master (
        output ctrl2fill_valid, ctrl2fill_index, ctrl2fill_way, ctrl2fill_tag,
        input  fill2ctrl_ready,
        input  mem_req_valid, mem_req_addr,
        output mem_req_ready,
        output mem_resp_valid, mem_resp_data, mem_resp_last,
        input  mem_resp_ready,
        input  fill2data_wen, fill2data_index, fill2data_way,
        input  fill2data_offset, fill2data_wdata,
        input  fill2tag_wen, fill2tag_index, fill2tag_way,
        input  fill2tag_tag, fill2tag_valid,
        input  fill_err
    );
endinterface

// File: rtl/icache_fill.sv
// I-cache line fill engine: fetches one 64-byte line as 8 beats,
// writes each beat to the data array, then marks the tag valid.
module icache_fill #(
    parameter int LINE_BEATS = 8,
    parameter int ADDR_W     = 56
) (
    input  logic          clock,
    input  logic          reset,
    icache_fill_if.slave  bus
);
    localparam int         TAG_W     = ADDR_W - 12;
    localparam logic [2:0] LAST_BEAT = 3'(LINE_BEATS - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RECV,
        TAG_WR,
        DONE
    } state_t;

    state_t           r_state;
    logic [5:0]       r_index;
    logic [2:0]       r_way;
    logic [TAG_W-1:0] r_tag;
    logic [2:0]       r_cnt;
    logic             r_req_valid;
    logic             r_resp_ready;
    logic             r_tag_wen;
    logic             r_done;

    logic             w_beat;
    logic             w_last_beat;

    assign w_beat      = r_resp_ready & bus.mem_resp_valid;
    assign w_last_beat = (r_cnt == LAST_BEAT);

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_index      <= '0;
            r_way        <= '0;
            r_tag        <= '0;
            r_cnt        <= '0;
            r_req_valid  <= 1'b0;
            r_resp_ready <= 1'b0;
            r_tag_wen    <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_tag_wen <= 1'b0;
            r_done    <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (bus.ctrl2fill_valid) begin
                        r_index     <= bus.ctrl2fill_index;
                        r_way       <= bus.ctrl2fill_way;
                        r_tag       <= bus.ctrl2fill_tag;
                        r_req_valid <= 1'b1;
                        r_state     <= REQ;
                    end
                end
                REQ: begin
                    if (bus.mem_req_ready) begin
                        r_req_valid  <= 1'b0;
                        r_resp_ready <= 1'b1;
                        r_cnt        <= '0;
                        r_state      <= RECV;
                    end
                end
                RECV: begin
                    // The beat count alone ends the line; last only flags errors.
                    if (bus.mem_resp_valid) begin
                        r_cnt <= r_cnt + 3'd1;
                        if (w_last_beat) begin
                            r_resp_ready <= 1'b0;
                            r_tag_wen    <= 1'b1;
                            r_state      <= TAG_WR;
                        end
                    end
                end
                TAG_WR: begin
                    r_done  <= 1'b1;
                    r_state <= DONE;
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_req_valid    = r_req_valid;
    assign bus.mem_req_addr     = {r_tag, r_index, 6'b0};
    assign bus.mem_resp_ready   = r_resp_ready;

    assign bus.fill2data_wen    = w_beat;
    assign bus.fill2data_index  = r_index;
    assign bus.fill2data_way    = r_way;
    assign bus.fill2data_offset = r_cnt;
    assign bus.fill2data_wdata  = bus.mem_resp_data;

    assign bus.fill2tag_wen     = r_tag_wen;
    assign bus.fill2tag_index   = r_index;
    assign bus.fill2tag_way     = r_way;
    assign bus.fill2tag_tag     = r_tag;
    assign bus.fill2tag_valid   = r_tag_wen;

    assign bus.fill2ctrl_ready  = r_done;
    assign bus.fill_err         = w_beat & (bus.mem_resp_last != w_last_beat);
endmodule

// File: tb/tb_icache_fill.sv
// Directed bench for icache_fill: a per-cycle vector table for two
// full fills, then hand-written stall, bubble and mid-fill reset runs.
module tb_icache_fill;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    icache_fill_if #(.ADDR_W(56)) b();

    icache_fill #(
        .LINE_BEATS(8),
        .ADDR_W(56)
    ) dut (
        .clock(clk),
        .reset(rst_n),
        .bus(b)
    );

    localparam logic [6:0] F_REQ  = 7'h40;
    localparam logic [6:0] F_RRDY = 7'h20;
    localparam logic [6:0] F_DWEN = 7'h10;
    localparam logic [6:0] F_TWEN = 7'h08;
    localparam logic [6:0] F_TVAL = 7'h04;
    localparam logic [6:0] F_DONE = 7'h02;
    localparam logic [6:0] F_ERR  = 7'h01;

    typedef struct {
        logic        cv;
        logic [5:0]  idx;
        logic [2:0]  way;
        logic [43:0] tag;
        logic        rdy;
        logic        rv;
        logic        last;
        logic [63:0] data;
        logic [6:0]  ef;
        logic [2:0]  eoff;
        logic [55:0] eaddr;
        logic [2:0]  eway;
    } vec_t;

    vec_t tbl[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [6:0] flags();
        return {b.mem_req_valid, b.mem_resp_ready, b.fill2data_wen,
                b.fill2tag_wen, b.fill2tag_valid, b.fill2ctrl_ready,
                b.fill_err};
    endfunction

    function automatic logic [61:0] bundle();
        return {b.fill2data_index, b.fill2data_way, b.fill2tag_index,
                b.fill2tag_way, b.fill2tag_tag};
    endfunction

    function automatic logic [61:0] exp_bundle(input logic [55:0] a,
                                               input logic [2:0] w);
        return {a[11:6], w, a[11:6], w, a[55:12]};
    endfunction

    function automatic logic [63:0] beat(input int i, input logic [7:0] s);
        return {8'hD0 ^ s, 24'h0, 24'hABCDEF, 8'(i)};
    endfunction

    task automatic drive(input logic cv, input logic [5:0] idx,
                         input logic [2:0] way, input logic [43:0] tag,
                         input logic rdy, input logic rv, input logic last,
                         input logic [63:0] d);
        b.ctrl2fill_valid = cv;
        b.ctrl2fill_index = idx;
        b.ctrl2fill_way   = way;
        b.ctrl2fill_tag   = tag;
        b.mem_req_ready   = rdy;
        b.mem_resp_valid  = rv;
        b.mem_resp_last   = last;
        b.mem_resp_data   = d;
    endtask

    task automatic row(input logic cv, input logic [5:0] idx,
                       input logic [2:0] way, input logic [43:0] tag,
                       input logic rdy, input logic rv, input logic last,
                       input logic [63:0] d, input logic [6:0] ef,
                       input logic [2:0] eoff, input logic [55:0] ea,
                       input logic [2:0] ew);
        vec_t v;
        v.cv = cv; v.idx = idx; v.way = way; v.tag = tag;
        v.rdy = rdy; v.rv = rv; v.last = last; v.data = d;
        v.ef = ef; v.eoff = eoff; v.eaddr = ea; v.eway = ew;
        tbl.push_back(v);
    endtask

    // One complete fill with req_wait stalled request cycles and two
    // bubble cycles after each beat whose bit is set in gap_after.
    task automatic fill_seq(input logic [5:0] idx, input logic [2:0] way,
                            input logic [43:0] tag, input int req_wait,
                            input logic [7:0] gap_after, input string nm);
        logic [55:0] ea;
        int nwr;
        int bub;
        int bt;
        ea  = {tag, idx, 6'b0};
        nwr = 0;
        bub = 0;
        bt  = 0;
        @(negedge clk);
        drive(1'b1, idx, way, tag, 1'b0, 1'b0, 1'b0, 64'h0);
        #1 chk({nm, "_idle"}, 64'(flags()), 64'(0));
        for (int c = 0; c <= req_wait; c++) begin
            @(negedge clk);
            drive(1'b0, 6'h3F, 3'h7, 44'hFFF, c == req_wait, 1'b0, 1'b0, 64'h0);
            #1 chk($sformatf("%s_req%0d", nm, c), 64'(flags()), 64'(F_REQ));
            chk($sformatf("%s_addr%0d", nm, c), 64'(b.mem_req_addr), 64'(ea));
        end
        while (bt < 8) begin
            @(negedge clk);
            if (bub > 0) begin
                drive(1'b0, 6'h0, 3'h0, 44'h0, 1'b0, 1'b0, 1'b0, 64'h0);
                #1 chk($sformatf("%s_bub%0d", nm, bt), 64'(flags()), 64'(F_RRDY));
                chk($sformatf("%s_hold%0d", nm, bt),
                    64'(b.fill2data_offset), 64'(bt));
                bub--;
            end else begin
                drive(1'b0, 6'h0, 3'h0, 44'h0, 1'b0, 1'b1, bt == 7,
                      beat(bt, 8'h5A));
                #1 chk($sformatf("%s_beat%0d", nm, bt),
                       64'(flags()), 64'(F_RRDY | F_DWEN));
                chk($sformatf("%s_off%0d", nm, bt),
                    64'(b.fill2data_offset), 64'(bt));
                if (gap_after[bt]) bub = 2;
                bt++;
            end
            if (b.fill2data_wen) nwr++;
        end
        @(negedge clk);
        drive(1'b0, 6'h0, 3'h0, 44'h0, 1'b0, 1'b0, 1'b0, 64'h0);
        #1 chk({nm, "_tagwr"}, 64'(flags()), 64'(F_TWEN | F_TVAL));
        chk({nm, "_tagbus"}, 64'(bundle()), 64'(exp_bundle(ea, way)));
        @(negedge clk);
        #1 chk({nm, "_done"}, 64'(flags()), 64'(F_DONE));
        @(negedge clk);
        #1 chk({nm, "_back"}, 64'(flags()), 64'(0));
        chk({nm, "_writes"}, 64'(nwr), 64'(8));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    initial begin
        logic [55:0] aa;
        logic [55:0] ab;
        aa = 56'h123140;
        ab = 56'h456240;

        // Fill A: back-to-back beats, last on beat 7.
        row(1, 6'd5, 3'd3, 44'h123, 0, 0, 0, 64'h0, 7'h0, 3'd0, 56'h0, 3'd0);
        row(0, 6'd0, 3'd0, 44'h0, 1, 0, 0, 64'h0, F_REQ, 3'd0, aa, 3'd3);
        for (int i = 0; i < 8; i++)
            row(0, 6'd0, 3'd0, 44'h0, 0, 1, i == 7, beat(i, 8'h00),
                F_RRDY | F_DWEN, 3'(i), aa, 3'd3);
        row(0, 6'd0, 3'd0, 44'h0, 0, 0, 0, 64'h0, F_TWEN | F_TVAL, 3'd0, aa, 3'd3);
        row(0, 6'd0, 3'd0, 44'h0, 0, 0, 0, 64'h0, F_DONE, 3'd0, aa, 3'd3);
        row(0, 6'd0, 3'd0, 44'h0, 0, 0, 0, 64'h0, 7'h0, 3'd0, aa, 3'd3);

        // Fill B: request held high with changing fields, early last on beat 4.
        row(1, 6'd9, 3'd1, 44'h456, 0, 0, 0, 64'h0, 7'h0, 3'd0, aa, 3'd3);
        row(1, 6'd10, 3'd2, 44'h999, 1, 0, 0, 64'h0, F_REQ, 3'd0, ab, 3'd1);
        for (int i = 0; i < 8; i++)
            row(1, 6'(11 + i), 3'(i), 44'h777, 0, 1, i == 4 || i == 7,
                beat(i, 8'h33),
                F_RRDY | F_DWEN | ((i == 4) ? F_ERR : 7'h0), 3'(i), ab, 3'd1);
        row(1, 6'd20, 3'd6, 44'h888, 0, 0, 0, 64'h0, F_TWEN | F_TVAL, 3'd0, ab, 3'd1);
        row(1, 6'd21, 3'd7, 44'haaa, 0, 0, 0, 64'h0, F_DONE, 3'd0, ab, 3'd1);
        row(0, 6'd0, 3'd0, 44'h0, 0, 0, 0, 64'h0, 7'h0, 3'd0, ab, 3'd1);

        drive(1'b0, 6'h0, 3'h0, 44'h0, 1'b0, 1'b0, 1'b0, 64'h0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 chk("rst_flags", 64'(flags()), 64'(0));
        chk("rst_addr", 64'(b.mem_req_addr), 64'(0));
        chk("rst_bus", 64'(bundle()), 64'(0));
        chk("rst_off", 64'(b.fill2data_offset), 64'(0));
        rst_n = 1'b1;

        foreach (tbl[k]) begin
            @(negedge clk);
            drive(tbl[k].cv, tbl[k].idx, tbl[k].way, tbl[k].tag,
                  tbl[k].rdy, tbl[k].rv, tbl[k].last, tbl[k].data);
            #1 chk($sformatf("vec%0d_flags", k), 64'(flags()), 64'(tbl[k].ef));
            chk($sformatf("vec%0d_addr", k),
                64'(b.mem_req_addr), 64'(tbl[k].eaddr));
            chk($sformatf("vec%0d_bus", k), 64'(bundle()),
                64'(exp_bundle(tbl[k].eaddr, tbl[k].eway)));
            if (tbl[k].ef[4]) begin
                chk($sformatf("vec%0d_off", k),
                    64'(b.fill2data_offset), 64'(tbl[k].eoff));
                chk($sformatf("vec%0d_wdata", k),
                    b.fill2data_wdata, tbl[k].data);
            end
        end

        fill_seq(6'd2, 3'd6, 44'hABC, 4, 8'h00, "stall");
        fill_seq(6'd63, 3'd0, 44'hFFFFFFFFFFF, 0, 8'b0010_0100, "gaps");

        // Reset sampled at the end of beat 3 abandons the fill.
        @(negedge clk);
        drive(1'b1, 6'd7, 3'd2, 44'h77, 1'b0, 1'b0, 1'b0, 64'h0);
        @(negedge clk);
        drive(1'b0, 6'd0, 3'd0, 44'h0, 1'b1, 1'b0, 1'b0, 64'h0);
        #1 chk("mrst_req", 64'(flags()), 64'(F_REQ));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(1'b0, 6'd0, 3'd0, 44'h0, 1'b0, 1'b1, 1'b0, beat(i, 8'h11));
            if (i == 3) rst_n = 1'b0;
            #1 chk($sformatf("mrst_beat%0d", i),
                   64'(flags()), 64'(F_RRDY | F_DWEN));
        end
        for (int i = 4; i < 8; i++) begin
            @(negedge clk);
            rst_n = 1'b1;
            drive(1'b0, 6'd0, 3'd0, 44'h0, 1'b0, 1'b1, i == 7, beat(i, 8'h11));
            #1 chk($sformatf("mrst_post%0d", i), 64'(flags()), 64'(0));
            chk($sformatf("mrst_addr%0d", i), 64'(b.mem_req_addr), 64'(0));
            chk($sformatf("mrst_off%0d", i), 64'(b.fill2data_offset), 64'(0));
        end
        @(negedge clk);
        drive(1'b0, 6'd0, 3'd0, 44'h0, 1'b0, 1'b0, 1'b0, 64'h0);
        #1 chk("mrst_quiet", 64'(flags()), 64'(0));
        fill_seq(6'd7, 3'd2, 44'h77, 0, 8'h00, "after_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
